// File: rtl/ex_m_pipe_reg.sv
// EX/MEM pipeline register: captures EX results, builds byte enables and store lanes,
// squashes misaligned accesses and tracks a sticky halt. Debug PC/counter under `EX_M_DEBUG_EN.
module ex_m_pipe_reg #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_valid_ex,
  input  logic [NB_DATA-1:0] i_alu_result_ex,
  input  logic [NB_DATA-1:0] i_rt_data_ex,
  input  logic [NB_ADDR-1:0] i_rd_ex,
  input  logic               i_regWrite_ex,
  input  logic               i_memRead_ex,
  input  logic               i_memWrite_ex,
  input  logic               i_memToReg_ex,
  input  logic               i_unsigned_ex,
  input  logic               i_halt_ex,
  input  logic [1:0]         i_bhw_ex,
  input  logic [NB_DATA-1:0] i_pc_ex,
  output logic               o_valid_m,
  output logic [NB_DATA-1:0] o_alu_result_m,
  output logic [NB_DATA-1:0] o_wdata_m,
  output logic [3:0]         o_be_m,
  output logic [NB_ADDR-1:0] o_rd_ex_m,
  output logic               o_regWrite_ex_m,
  output logic               o_memRead_m,
  output logic               o_memWrite_m,
  output logic               o_memToReg_m,
  output logic               o_unsigned_m,
  output logic [1:0]         o_bhw_m,
  output logic               o_misalign_m,
  output logic               o_halt_m,
  output logic               o_halted,
  output logic [NB_DATA-1:0] o_pc_m,
  output logic [31:0]        o_retired_cnt
);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_RSVD = 2'b10,
    SZ_WORD = 2'b11
  } size_e;

  // Everything a bubble must clear lives in one struct so a bubble is just '0.
  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       unsgn;
    logic       misalign;
    logic       halt;
    logic [3:0] be;
  } ctrl_t;

  ctrl_t              ctrl_q, ctrl_d, cap_ctrl;
  logic [NB_DATA-1:0] alu_q, alu_d;
  logic [NB_DATA-1:0] wdata_q, wdata_d, cap_wdata;
  logic [NB_ADDR-1:0] rd_q, rd_d;
  logic [1:0]         bhw_q, bhw_d;
  logic               halted_q, halted_d;

  logic [1:0] addr;
  logic [3:0] be_raw;
  logic       size_misaligned;
  logic       mem_access;
  logic       capture;
  logic       bubble;

  assign bubble  = i_flush | (~i_stall & halted_q);
  assign capture = ~i_flush & ~i_stall & ~halted_q;

  // Byte-lane decode of the effective address for the requested access size.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    addr            = i_alu_result_ex[1:0];
    be_raw          = 4'b1111;
    size_misaligned = 1'b0;
    cap_wdata       = i_rt_data_ex;
    unique case (size_e'(i_bhw_ex))
      SZ_BYTE: begin
        be_raw    = 4'b0001 << addr;
        cap_wdata = {4{i_rt_data_ex[7:0]}};
      end
      SZ_HALF: begin
        be_raw          = addr[1] ? 4'b1100 : 4'b0011;
        size_misaligned = addr[0];
        cap_wdata       = {2{i_rt_data_ex[15:0]}};
      end
      SZ_RSVD, SZ_WORD: begin
        be_raw          = 4'b1111;
        size_misaligned = (addr != 2'b00);
      end
    endcase
  end

  // Qualified control for the instruction currently in EX.
  always_comb begin
    mem_access        = i_valid_ex & (i_memRead_ex | i_memWrite_ex);
    cap_ctrl          = '0;
    cap_ctrl.valid    = i_valid_ex;
    cap_ctrl.misalign = mem_access & size_misaligned;
    cap_ctrl.memread  = i_valid_ex & i_memRead_ex  & ~cap_ctrl.misalign;
    cap_ctrl.memwrite = i_valid_ex & i_memWrite_ex & ~cap_ctrl.misalign;
    cap_ctrl.memtoreg = i_valid_ex & i_memToReg_ex & ~cap_ctrl.misalign;
    cap_ctrl.unsgn    = i_valid_ex & i_unsigned_ex;
    cap_ctrl.halt     = i_valid_ex & i_halt_ex;
    cap_ctrl.regwrite = i_valid_ex & i_regWrite_ex & (i_rd_ex != '0) & ~cap_ctrl.misalign;
    cap_ctrl.be       = (cap_ctrl.memread | cap_ctrl.memwrite) ? be_raw : 4'b0000;
  end

  // Next state: flush / halted bubble clears control, stall holds, otherwise capture.
  always_comb begin
    ctrl_d   = ctrl_q;
    alu_d    = alu_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    bhw_d    = bhw_q;
    halted_d = halted_q;
    if (bubble) begin
      ctrl_d = '0;
    end else if (capture) begin
      ctrl_d   = cap_ctrl;
      alu_d    = i_alu_result_ex;
      wdata_d  = cap_wdata;
      rd_d     = i_rd_ex;
      bhw_d    = i_bhw_ex;
      halted_d = halted_q | cap_ctrl.halt;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) begin
      ctrl_q   <= '0;
      alu_q    <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      bhw_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      alu_q    <= alu_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      bhw_q    <= bhw_d;
      halted_q <= halted_d;
    end
  end

`ifdef EX_M_DEBUG_EN
  logic [NB_DATA-1:0] pc_q, pc_d;
  logic [31:0]        cnt_q, cnt_d;

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    if (bubble) begin
      pc_d = '0;
    end else if (capture) begin
      pc_d  = i_pc_ex;
      cnt_d = i_valid_ex ? cnt_q + 32'd1 : cnt_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_pc_m        = pc_q;
  assign o_retired_cnt = cnt_q;
`else
  logic unused_pc;
  assign unused_pc     = ^i_pc_ex;
  assign o_pc_m        = '0;
  assign o_retired_cnt = '0;
`endif

  assign o_valid_m       = ctrl_q.valid;
  assign o_alu_result_m  = alu_q;
  assign o_wdata_m       = wdata_q;
  assign o_be_m          = ctrl_q.be;
  assign o_rd_ex_m       = rd_q;
  assign o_regWrite_ex_m = ctrl_q.regwrite;
  assign o_memRead_m     = ctrl_q.memread;
  assign o_memWrite_m    = ctrl_q.memwrite;
  assign o_memToReg_m    = ctrl_q.memtoreg;
  assign o_unsigned_m    = ctrl_q.unsgn;
  assign o_bhw_m         = bhw_q;
  assign o_misalign_m    = ctrl_q.misalign;
  assign o_halt_m        = ctrl_q.halt;
  assign o_halted        = halted_q;

endmodule

// File: doc/ex_m_pipe_reg.md
# ex_m_pipe_reg

EX/MEM pipeline register of the 5-stage MIPS core. Captures each EX-stage result and its memory/writeback control, and presents them to the MEM stage and to the ID-stage forwarding logic (`o_rd_ex_m`, `o_regWrite_ex_m`). It also:
- applies stall, flush and sticky halt;
- builds byte enables and lane-replicated store data;
- squashes misaligned memory accesses.

## Interface
Parameters:
- NB_DATA, 32, datapath width (byte-lane logic requires 32)
- NB_ADDR, 5, register address width

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_stall  in  1  hold all registers
- i_flush  in  1  load a bubble
- i_valid_ex  in  1  EX holds a real instruction
- i_alu_result_ex  in  NB_DATA  ALU result / effective address
- i_rt_data_ex  in  NB_DATA  forwarded rt value (store data)
- i_rd_ex  in  NB_ADDR  destination register
- i_regWrite_ex, i_memRead_ex, i_memWrite_ex, i_memToReg_ex, i_unsigned_ex, i_halt_ex  in  1 each  control
- i_bhw_ex  in  2  access size: 00 byte, 01 half, 11 word, 10 treated as word
- i_pc_ex  in  NB_DATA  instruction PC
- o_valid_m  out  1  MEM holds a real instruction
- o_alu_result_m  out  NB_DATA  registered ALU result
- o_wdata_m  out  NB_DATA  lane-replicated store data
- o_be_m  out  4  byte enables
- o_rd_ex_m  out  NB_ADDR  destination register to MEM and forwarding
- o_regWrite_ex_m  out  1  qualified register write
- o_memRead_m, o_memWrite_m, o_memToReg_m, o_unsigned_m  out  1 each  qualified control
- o_bhw_m  out  2  access size
- o_misalign_m  out  1  misaligned access squashed
- o_halt_m  out  1  halt instruction in MEM
- o_halted  out  1  sticky halt flag
- o_pc_m  out  NB_DATA  debug PC
- o_retired_cnt  out  32  debug capture counter

## Operation
- Per-edge priority: i_rst > i_flush > i_stall > halted > capture.
- **Reset.** Every output is 0, including o_halted, o_retired_cnt and o_pc_m.
- **Flush.** o_valid_m and all control outputs go to 0, as do o_be_m, o_misalign_m and o_halt_m. Data fields may keep stale values.
- **Stall.** All registers hold, including o_halted and the counter.
- **Halted.** Once o_halted=1, every non-stalled edge loads a bubble, exactly as flush does.
- **Capture.** Register all EX inputs. o_valid_m = i_valid_ex.
- **Halt.** If i_valid_ex & i_halt_ex: set o_halt_m=1 for that instruction and set o_halted=1 on the same edge.
- **Alignment.** addr = i_alu_result_ex[1:0].
  - byte: be = 1<<addr, never misaligned.
  - half: be = addr[1] ? 1100 : 0011; misaligned if addr[0].
  - word: be = 1111; misaligned if addr != 0.
- **Misalignment.** o_misalign_m = valid & (memRead|memWrite) & misaligned.
  - When o_misalign_m=1, force o_memRead_m, o_memWrite_m, o_memToReg_m, o_regWrite_ex_m and o_be_m to 0.
- **be qualification.** o_be_m is 0 unless o_memWrite_m or o_memRead_m is 1.
- **Store data.**
  - byte: {4{rt[7:0]}}
  - half: {2{rt[15:0]}}
  - word: rt
- **Register-write qualification.** o_regWrite_ex_m = valid & regWrite & (rd != 0) & !misalign. Writes to $0 never forward.
- All control outputs are ANDed with valid; an invalid slot never asserts control.

## Timing
- Latency is one cycle, EX to MEM.
- All outputs are driven directly from flops; there is no combinational input-to-output path.
- A flush and stall in the same cycle resolves to flush.
- Asserting reset mid-stall clears everything on that edge.
- A halt captured while i_stall=1 is not seen until the stall releases.

## Configuration
- Macro: EX_M_DEBUG_EN.
- **Defined:**
  - o_pc_m registers i_pc_ex on capture and is zeroed on flush or halted-bubble edges.
  - o_retired_cnt increments by 1 on each capture edge where i_valid_ex=1. It does not increment on stall, flush or halted-bubble edges. It wraps from 0xFFFFFFFF to 0.
- **Undefined:** o_pc_m and o_retired_cnt are constant 0 and no flops are inferred for them.

## Test plan
- Reset, then capture {valid=1, regWrite=1, rd=8, alu=0x1234} → next cycle o_rd_ex_m=8, o_regWrite_ex_m=1, o_alu_result_m=0x1234.
- Capture with rd=0, regWrite=1 → o_regWrite_ex_m=0, o_valid_m=1.
- sb with alu=0x103, rt=0xAABBCCDD → o_be_m=1000, o_wdata_m=0xDDDDDDDD, o_memWrite_m=1.
- sw at alu=0x102 → o_misalign_m=1, o_memWrite_m=0, o_be_m=0.
- Hold i_stall for 3 cycles with changing inputs → outputs unchanged. Assert flush and stall together → o_valid_m=0.
- Capture halt, then three more valid instructions → o_halted=1 stays set, o_valid_m=0 for the following captures. With EX_M_DEBUG_EN, o_retired_cnt stops at its value including the halt. Reset → o_halted=0.
